// File: rtl/tff_toggle_monitor.sv
// Watches the q output of a T flip-flop stage. It flags rising and falling toggles,
// counts toggles while enabled, and measures the rise-to-rise period of q.
module tff_toggle_monitor #(
   parameter int unsigned      CNT_W    = 8,
   parameter logic [CNT_W-1:0] TC_VALUE = 8'd16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             q_in,
   input  logic             enable,
   input  logic             clear,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic             cnt_wrap,
   output logic             tc_hit,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             period_ovf,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             q_d;
   logic             primed;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] cnt_inc;
   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] pcnt;
   logic [CNT_W-1:0] pcnt_n;
   logic             capture;

   // primed masks the first sampled level so q_in=1 at reset release is not a rise.
   assign rise    = primed & q_in & ~q_d;
   assign fall    = primed & ~q_in & q_d;
   assign cnt_inc = toggle_cnt + CNT_ONE;

   always_ff @(posedge clk) begin
      if (!rst) begin
         q_d        <= 1'b0;
         primed     <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         q_d <= q_in;
         if (clear) begin
            primed     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
         end else begin
            primed     <= 1'b1;
            rise_pulse <= rise;
            fall_pulse <= fall;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         toggle_cnt <= '0;
         cnt_wrap   <= 1'b0;
         tc_hit     <= 1'b0;
      end else if (clear) begin
         toggle_cnt <= '0;
         cnt_wrap   <= 1'b0;
         tc_hit     <= 1'b0;
      end else begin
         tc_hit <= 1'b0;
         if (enable && (rise || fall)) begin
            toggle_cnt <= cnt_inc;
            tc_hit     <= (cnt_inc == TC_VALUE);
            if (toggle_cnt == CNT_MAX) begin
               cnt_wrap <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_n = state;
      pcnt_n  = pcnt;
      capture = 1'b0;
      case (state)
         IDLE: begin
            pcnt_n = '0;
            if (enable) begin
               state_n = ARMED;
            end
         end
         ARMED: begin
            pcnt_n = '0;
            if (!enable) begin
               state_n = IDLE;
            end else if (rise) begin
               state_n = MEASURE;
               pcnt_n  = CNT_ONE;
            end
         end
         MEASURE: begin
            // Dropping enable wins over a coincident rise: no capture.
            if (!enable) begin
               state_n = IDLE;
               pcnt_n  = '0;
            end else if (rise) begin
               capture = 1'b1;
               pcnt_n  = CNT_ONE;
            end else if (pcnt != CNT_MAX) begin
               pcnt_n = pcnt + CNT_ONE;
            end
         end
         default: begin
            state_n = IDLE;
            pcnt_n  = '0;
         end
      endcase
      if (clear) begin
         state_n = IDLE;
         pcnt_n  = '0;
         capture = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         pcnt  <= '0;
      end else begin
         state <= state_n;
         pcnt  <= pcnt_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         period       <= '0;
         period_valid <= 1'b0;
         period_ovf   <= 1'b0;
      end else if (clear) begin
         period       <= '0;
         period_valid <= 1'b0;
         period_ovf   <= 1'b0;
      end else begin
         period_valid <= capture;
         if (capture) begin
            period     <= pcnt;
            period_ovf <= (pcnt == CNT_MAX);
         end
      end
   end

   assign fsm_state = state;

endmodule

// File: doc/tff_toggle_monitor.md
Name: tff_toggle_monitor

Overview:
Downstream consumer of the T flip-flop output q. Samples q each clk and detects rising and falling toggles. Counts toggles while enabled. Measures the period of q, in clk cycles between successive rising edges, with a small FSM. Used to check divider/toggle behaviour of the T-ff stage in system and to drive status logic.

Parameters:
CNT_W, 8, width of toggle counter, period counter and period output
TC_VALUE, 8'd16, toggle count at which tc_hit pulses; must be < 2^CNT_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst=0 resets on the next clk rising edge)
q_in  input  1  q from the T flip-flop, same clk domain
enable  input  1  counting/measurement enable
clear  input  1  synchronous clear of counts, flags and FSM
rise_pulse  output  1  one-cycle pulse on a detected 0->1 of q_in
fall_pulse  output  1  one-cycle pulse on a detected 1->0 of q_in
toggle_cnt  output  CNT_W  number of edges (rise+fall) seen while enable=1
cnt_wrap  output  1  sticky; set when toggle_cnt wraps max->0
tc_hit  output  1  one-cycle pulse when toggle_cnt becomes TC_VALUE
period  output  CNT_W  last measured rise-to-rise period in clk cycles
period_valid  output  1  one-cycle pulse when period updates
period_ovf  output  1  qualifies period_valid; 1 if the measured period saturated

Behaviour:
- Reset (rst=0 at clk edge): all outputs 0; q_d=0; primed=0; FSM=IDLE; internal period counter pcnt=0.
- Edge detect:
  - q_d <= q_in every cycle.
  - primed <= 1 on the first cycle after reset or clear.
  - While primed=0, no edges are generated. This prevents a spurious rise when q_in=1 at reset release.
  - rise = primed & q_in & ~q_d; fall = primed & ~q_in & q_d.
  - rise_pulse/fall_pulse are registered: high for exactly one cycle, in the cycle after the clk edge that first sampled the new q_in level.
  - Edge pulses are produced regardless of enable.
- Toggle counter:
  - When enable=1 and (rise|fall): toggle_cnt <= toggle_cnt+1 (mod 2^CNT_W), in the same cycle the edge pulse is registered.
  - Wrap from all-ones to 0 sets cnt_wrap. cnt_wrap holds until clear or reset.
  - tc_hit is registered; pulses once when the incremented value equals TC_VALUE. It fires again only after a wrap.
  - When enable=0, toggle_cnt holds.
- Period FSM: states IDLE, ARMED, MEASURE.
  - IDLE: pcnt=0. enable=1 -> ARMED.
  - ARMED: waits for the first rise. On rise -> MEASURE with pcnt<=1. enable=0 -> IDLE.
  - MEASURE: each cycle pcnt <= pcnt+1, saturating at 2^CNT_W-1. On rise:
    - period <= pcnt; period_valid=1 for one cycle.
    - period_ovf <= (pcnt==max).
    - pcnt <= 1; stays in MEASURE.
  - MEASURE: enable=0 -> IDLE. pcnt clears; period holds its last value; no valid pulse.
  - period_ovf is meaningful only with period_valid. It holds its last value otherwise.
- clear=1 (priority below rst, above all else):
  - toggle_cnt, cnt_wrap, period, period_ovf <= 0; FSM <= IDLE; primed <= 0.
  - Pulses forced to 0 in the following cycle.
- Simultaneous events:
  - enable falling in the same cycle as a rise in MEASURE: the rise is ignored, go to IDLE.
  - Rise and a pcnt saturation in the same cycle: report period=max with period_ovf=1.
- Latency: q_in change to pulse/count/period update is 1 registered cycle after the sampling edge.

Test Plan:
- Reset priming: hold rst=0 with q_in=1 for 3 clk, release with q_in=1 steady -> no rise_pulse; all outputs 0.
- Toggle every cycle: enable=1, T-ff driven with T=1 so q_in alternates each clk, 20 clk -> rise/fall alternate each cycle; period=2 with period_valid every 2nd cycle; tc_hit once when toggle_cnt=16.
- Enable gating: q_in toggles with enable=0 for 10 edges -> toggle_cnt stays 0, FSM stays IDLE. Then raise enable -> ARMED; first period_valid only after the second rise.
- Slow period / saturation: CNT_W=4, rise, then q_in held for 20 cycles, then rise -> period=15, period_ovf=1 with period_valid.
- Wrap: CNT_W=4, 17 edges with enable=1 -> toggle_cnt=1, cnt_wrap=1. Apply clear -> all zero; next edge is not counted until primed.
- Mid-operation reset: rst=0 for one clk in MEASURE -> next cycle FSM=IDLE and all outputs 0; q_in=1 at release gives no spurious rise.
